bbox_detect: RTL and testbench

BBOX_DETECT -- requirements
Module: bbox_detect

---
 rtl/bbox_detect_pkg.sv | 14 +
 rtl/bbox_detect_if.sv | 26 ++
 rtl/vsync_edge.sv | 22 ++
 rtl/bbox_detect.sv | 132 +++++++++++++
 tb/tb_bbox_detect.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bbox_detect_pkg.sv
// Shared vision package: bbox_detect FSM encoding and run-length limits.
package bbox_detect_pkg;

    typedef enum logic [0:0] {
        StWait = 1'b0,
        StScan = 1'b1
    } bbox_state_e;

    localparam int unsigned RunMinLo = 1;
    localparam int unsigned RunMinHi = 15;
    // Wide enough to hold RunMinHi.
    localparam int unsigned RunCntW  = 4;

endpackage

// File: rtl/bbox_detect_if.sv
// Pixel stream in, bounding-box result out; master drives video, slave is the detector.
interface bbox_detect_if #(
    parameter int unsigned CW = 12
);
    logic          i_vsync;
    logic          i_de;
    logic          wb;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          o_vsync_pos;
    logic [CW-1:0] hcount_l;
    logic [CW-1:0] hcount_r;
    logic [CW-1:0] vcount_l;
    logic [CW-1:0] vcount_r;
    logic          box_valid;

    modport master (
        output i_vsync, i_de, wb, hcount, vcount,
        input  o_vsync_pos, hcount_l, hcount_r, vcount_l, vcount_r, box_valid
    );

    modport slave (
        input  i_vsync, i_de, wb, hcount, vcount,
        output o_vsync_pos, hcount_l, hcount_r, vcount_l, vcount_r, box_valid
    );
endinterface

// File: rtl/vsync_edge.sv
// Registered rising-edge detector for vsync; pulse lasts one pixelclk cycle.
module vsync_edge (
    input  logic pixelclk,
    input  logic reset_n,
    input  logic i_vsync,
    output logic o_vsync_pos
);
    logic vsync_q;
    logic pos_q;

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            pos_q   <= 1'b0;
        end else begin
            vsync_q <= i_vsync;
            pos_q   <= i_vsync & ~vsync_q;
        end
    end

    assign o_vsync_pos = pos_q;
endmodule

// File: rtl/bbox_detect.sv
// Bounding box of qualifying black pixel runs, latched per frame as exclusive bounds.
module bbox_detect
    import bbox_detect_pkg::*;
#(
    parameter int unsigned RUN_MIN = 3,
    parameter int unsigned CW      = 12
) (
    input logic          pixelclk,
    input logic          reset_n,
    bbox_detect_if.slave bus
);
    if (RUN_MIN < RunMinLo || RUN_MIN > RunMinHi) begin : gen_run_min_check
        $error("bbox_detect: RUN_MIN out of range");
    end

    localparam logic [RunCntW-1:0] RunMinC = RunCntW'(RUN_MIN);
    localparam logic [CW-1:0]      RunOff  = CW'(RUN_MIN - 1);
    localparam logic [CW-1:0]      Ones    = '1;

    function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == Ones) ? Ones : v + 1'b1;
    endfunction

    logic vsync_pos;

    vsync_edge u_vsync_edge (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .i_vsync     (bus.i_vsync),
        .o_vsync_pos (vsync_pos)
    );

    bbox_state_e          state_q, state_d;
    logic [RunCntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                 found_q, found_d;
    logic [CW-1:0]        min_x_q, min_x_d, max_x_q, max_x_d;
    logic [CW-1:0]        min_y_q, min_y_d, max_y_q, max_y_d;
    logic [CW-1:0]        hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
    logic                 valid_q, valid_d;
    logic                 black, qualify, first;
    logic [CW-1:0]        x0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:  if (vsync_pos) state_d = StScan;
            StScan:  state_d = StScan;
            default: state_d = StWait;
        endcase

        black   = bus.i_de & ~bus.wb;
        cnt_inc = (cnt_q == RunMinC) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = black ? cnt_inc : '0;
        // Pixels in WAIT and in the pulse cycle itself never reach the accumulators.
        qualify = black && (cnt_inc >= RunMinC) && (state_q == StScan) && !vsync_pos;
        first   = qualify && (cnt_q != RunMinC);
        x0      = bus.hcount - RunOff;

        found_d = found_q;
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        valid_d = valid_q;

        if (vsync_pos) begin
            if (state_q == StScan) begin
                hl_d    = found_q ? dec_sat(min_x_q) : '0;
                hr_d    = found_q ? inc_sat(max_x_q) : '0;
                vl_d    = found_q ? dec_sat(min_y_q) : '0;
                vr_d    = found_q ? inc_sat(max_y_q) : '0;
                valid_d = found_q;
            end
            found_d = 1'b0;
            min_x_d = Ones;
            max_x_d = '0;
            min_y_d = Ones;
            max_y_d = '0;
        end else if (qualify) begin
            found_d = 1'b1;
            if (first && (x0 < min_x_q)) min_x_d = x0;
            if (bus.hcount > max_x_q)    max_x_d = bus.hcount;
            if (bus.vcount < min_y_q)    min_y_d = bus.vcount;
            if (bus.vcount > max_y_q)    max_y_d = bus.vcount;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            cnt_q   <= '0;
            found_q <= 1'b0;
            min_x_q <= Ones;
            max_x_q <= '0;
            min_y_q <= Ones;
            max_y_q <= '0;
            hl_q    <= '0;
            hr_q    <= '0;
            vl_q    <= '0;
            vr_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            vl_q    <= vl_d;
            vr_q    <= vr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_vsync_pos = vsync_pos;
    assign bus.hcount_l    = hl_q;
    assign bus.hcount_r    = hr_q;
    assign bus.vcount_l    = vl_q;
    assign bus.vcount_r    = vr_q;
    assign bus.box_valid   = valid_q;
endmodule

// File: tb/tb_bbox_detect.sv
// Scoreboard bench for bbox_detect: frames push expected boxes, a monitor checks on each pulse.
module tb_bbox_detect;
    typedef struct packed {
        logic [11:0] hl;
        logic [11:0] hr;
        logic [11:0] vl;
        logic [11:0] vr;
        logic        v;
    } box_t;

    logic pixelclk = 1'b0;
    logic reset_n  = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    box_t sb[$];

    bbox_detect_if #(.CW(12)) bus ();

    bbox_detect #(
        .RUN_MIN (3),
        .CW      (12)
    ) dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 pixelclk = ~pixelclk;

    function automatic box_t mk(input int hl, input int hr, input int vl, input int vr,
                                input bit v);
        box_t b;
        b.hl = 12'(hl);
        b.hr = 12'(hr);
        b.vl = 12'(vl);
        b.vr = 12'(vr);
        b.v  = v;
        return b;
    endfunction

    function automatic box_t cur();
        return {bus.hcount_l, bus.hcount_r, bus.vcount_l, bus.vcount_r, bus.box_valid};
    endfunction

    task automatic check(input string name, input box_t got, input box_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got l/r/t/b=%0d/%0d/%0d/%0d valid=%0b, expected %0d/%0d/%0d/%0d valid=%0b",
                     name, got.hl, got.hr, got.vl, got.vr, got.v,
                     exp.hl, exp.hr, exp.vl, exp.vr, exp.v);
        end
    endtask

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    // One active line: cols c0..c0+n-1 on row, black for b0..b1, then two blanking cycles.
    task automatic line(input int row, input int c0, input int n, input int b0, input int b1);
        for (int c = c0; c < c0 + n; c++) begin
            bus.i_de   = 1'b1;
            bus.hcount = 12'(c);
            bus.vcount = 12'(row);
            bus.wb     = !(c >= b0 && c <= b1);
            tick();
        end
        bus.i_de = 1'b0;
        bus.wb   = 1'b1;
        tick();
        tick();
    endtask

    task automatic vsync(input box_t e);
        sb.push_back(e);
        bus.i_vsync = 1'b1;
        repeat (3) tick();
        bus.i_vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: outputs must hold through the pulse cycle, then show the new latch.
    initial begin : monitor
        box_t prev;
        box_t e;
        prev = '0;
        forever begin
            @(negedge pixelclk);
            if (!reset_n) begin
                prev = '0;
            end else if (bus.o_vsync_pos) begin
                check("hold", cur(), prev);
                @(negedge pixelclk);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got a vsync pulse, expected none");
                end else begin
                    e = sb.pop_front();
                    check("latch", cur(), e);
                    prev = e;
                end
            end
        end
    end

    initial begin : stim
        box_t zero;
        zero = '0;
        bus.i_vsync = 1'b0;
        bus.i_de    = 1'b0;
        bus.wb      = 1'b1;
        bus.hcount  = '0;
        bus.vcount  = '0;
        repeat (3) tick();
        check("reset_box", cur(), zero);
        check("reset_pulse", {48'd0, bus.o_vsync_pos}, zero);
        reset_n = 1'b1;
        tick();

        // Partial frame before first vsync: ignored.
        line(5, 0, 20, 2, 10);
        vsync(zero);

        // Single 5-pixel run.
        line(9, 96, 14, 200, 200);
        line(10, 96, 14, 100, 104);
        vsync(mk(99, 105, 9, 11, 1));

        // Only pairs: nothing qualifies.
        line(20, 0, 20, 3, 4);
        line(21, 0, 20, 10, 11);
        vsync(zero);

        // Saturating corners.
        line(0, 0, 10, 0, 4);
        line(1, 0, 10, 0, 4);
        line(4095, 4085, 11, 4090, 4095);
        vsync(mk(0, 4095, 0, 4095, 1));

        // Run split across line end does not qualify; a full run at line end does.
        line(30, 630, 10, 638, 639);
        line(31, 0, 10, 0, 0);
        line(40, 630, 10, 637, 639);
        vsync(mk(636, 640, 39, 41, 1));

        // Two rows, then a run that reaches RUN_MIN exactly in the pulse cycle.
        line(50, 195, 21, 200, 209);
        line(60, 140, 20, 150, 152);
        sb.push_back(mk(149, 210, 49, 61, 1));
        bus.vcount = 12'd70;
        bus.wb     = 1'b0;
        bus.i_de   = 1'b1;
        bus.hcount = 12'd300;
        tick();
        bus.hcount  = 12'd301;
        bus.i_vsync = 1'b1;
        tick();
        bus.hcount = 12'd302;
        tick();
        bus.i_de = 1'b0;
        bus.wb   = 1'b1;
        tick();
        bus.i_vsync = 1'b0;
        repeat (3) tick();

        // Empty frame: the discarded pixel must not count.
        line(80, 0, 10, 100, 100);
        vsync(zero);

        line(100, 8, 8, 10, 12);
        vsync(mk(9, 13, 99, 101, 1));

        // Mid-frame reset with a box latched.
        line(5, 0, 16, 0, 9);
        reset_n = 1'b0;
        #1;
        check("midreset_box", cur(), zero);
        repeat (3) tick();
        check("midreset_hold", cur(), zero);
        reset_n = 1'b1;
        tick();
        line(7, 0, 16, 0, 9);
        vsync(zero);
        line(200, 45, 16, 50, 54);
        vsync(mk(49, 55, 199, 201, 1));

        repeat (5) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expect: got %0d unconsumed entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
